// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the data-cache controller.
// Holds the FSM state enum, address field widths and line geometry.
package dcache_pkg;

    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int OFF_W          = 3;
    localparam int DEF_INDEX_W    = 5;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        ALLOC,
        RETRY
    } state_t;

    // Byte address of word w within a line given its {tag, index}.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-OFF_W-1:0] line,
        input logic [1:0]              w
    );
        return {line, w, 1'b0};
    endfunction

endpackage

// File: rtl/dcache_ctrl_read_return_tracker.sv
// Tracks accepted memory reads until their data returns MEM_LAT cycles later.
// Ports: clk, rst (async active-low), rd_acc/rd_word in, fill_valid/fill_word out.
module read_return_tracker #(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_acc,
    input  logic [1:0] rd_word,
    output logic       fill_valid,
    output logic [1:0] fill_word
);

    logic [MEM_LAT-1:0]      vld;
    logic [MEM_LAT-1:0][1:0] wrd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            wrd <= '0;
        end else begin
            vld[0] <= rd_acc;
            wrd[0] <= rd_word;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld[i] <= vld[i-1];
                wrd[i] <= wrd[i-1];
            end
        end
    end

    assign fill_valid = vld[MEM_LAT-1];
    assign fill_word  = wrd[MEM_LAT-1];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped data-cache controller: hit, dirty writeback, line fill, retry.
// Ports: processor side (Rd/Wr/Addr/DataIn -> DataOut/Done/Stall/CacheHit/Err),
// perf pulses (dcache_req/dcache_hit), cache array (c_*), main memory (m_*).
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter  int MEM_LAT = 2,
    parameter  int INDEX_W = DEF_INDEX_W,
    localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Rd,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              Err,
    output logic              dcache_req,
    output logic              dcache_hit,
    output logic              c_en,
    output logic              c_comp,
    output logic              c_write,
    output logic              c_valid_in,
    output logic [INDEX_W-1:0] c_index,
    output logic [OFF_W-1:0]  c_offset,
    output logic [TAG_W-1:0]  c_tag_in,
    output logic [DATA_W-1:0] c_data_in,
    input  logic              c_hit,
    input  logic              c_dirty,
    input  logic              c_valid,
    input  logic [TAG_W-1:0]  c_tag_out,
    input  logic [DATA_W-1:0] c_data_out,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data_in,
    output logic              m_wr,
    output logic              m_rd,
    input  logic [DATA_W-1:0] m_data_out,
    input  logic              m_stall
);

    state_t              state;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_data;
    logic                req_wr;
    logic [TAG_W-1:0]    vic_tag;
    logic [1:0]          wb_cnt;
    logic [2:0]          iss_cnt;
    logic [1:0]          fill_cnt;

    logic                bad;
    logic                go;
    logic                lookup_hit;
    logic                issue;
    logic                iss_acc;
    logic                fill_valid;
    logic [1:0]          fill_word;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;

    assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx    = req_addr[OFF_W +: INDEX_W];
    assign bad        = (Rd | Wr) & ((Rd & Wr) | Addr[0]);
    assign go         = (Rd ^ Wr) & ~Addr[0];
    assign lookup_hit = c_hit & c_valid;
    assign issue      = (state == ALLOC) &&
                        (iss_cnt != 3'(WORDS_PER_LINE));
    assign iss_acc    = issue & ~m_stall;

    read_return_tracker #(
        .MEM_LAT (MEM_LAT)
    ) u_trk (
        .clk        (clk),
        .rst        (rst),
        .rd_acc     (iss_acc),
        .rd_word    (iss_cnt[1:0]),
        .fill_valid (fill_valid),
        .fill_word  (fill_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            req_addr <= '0;
            req_data <= '0;
            req_wr   <= 1'b0;
            vic_tag  <= '0;
            wb_cnt   <= '0;
            iss_cnt  <= '0;
            fill_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go && !lookup_hit) begin
                        req_addr <= Addr;
                        req_data <= DataIn;
                        req_wr   <= Wr;
                        vic_tag  <= c_tag_out;
                        wb_cnt   <= '0;
                        iss_cnt  <= '0;
                        fill_cnt <= '0;
                        state    <= (c_valid & c_dirty) ? WB : ALLOC;
                    end
                end
                WB: begin
                    if (!m_stall) begin
                        wb_cnt <= wb_cnt + 2'd1;
                        if (wb_cnt == 2'd3)
                            state <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (iss_acc)
                        iss_cnt <= iss_cnt + 3'd1;
                    if (fill_valid) begin
                        fill_cnt <= fill_cnt + 2'd1;
                        if (fill_cnt == 2'd3)
                            state <= RETRY;
                    end
                end
                RETRY: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Everything is forced low while rst is asserted, even with a request held.
    always_comb begin
        DataOut    = '0;
        Done       = 1'b0;
        Stall      = 1'b0;
        CacheHit   = 1'b0;
        Err        = 1'b0;
        dcache_req = 1'b0;
        dcache_hit = 1'b0;
        c_en       = 1'b0;
        c_comp     = 1'b0;
        c_write    = 1'b0;
        c_valid_in = 1'b0;
        c_index    = '0;
        c_offset   = '0;
        c_tag_in   = '0;
        c_data_in  = '0;
        m_addr     = '0;
        m_data_in  = '0;
        m_wr       = 1'b0;
        m_rd       = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (bad) begin
                        Err  = 1'b1;
                        Done = 1'b1;
                    end else if (go) begin
                        c_en       = 1'b1;
                        c_comp     = 1'b1;
                        c_write    = Wr;
                        c_index    = Addr[OFF_W +: INDEX_W];
                        c_offset   = Addr[OFF_W-1:0];
                        c_tag_in   = Addr[ADDR_W-1 -: TAG_W];
                        c_data_in  = DataIn;
                        dcache_req = 1'b1;
                        if (lookup_hit) begin
                            Done       = 1'b1;
                            CacheHit   = 1'b1;
                            dcache_hit = 1'b1;
                            DataOut    = Rd ? c_data_out : '0;
                        end
                    end
                end
                WB: begin
                    Stall     = 1'b1;
                    c_en      = 1'b1;
                    c_index   = req_idx;
                    c_offset  = {wb_cnt, 1'b0};
                    c_tag_in  = req_tag;
                    m_wr      = 1'b1;
                    m_addr    = word_addr({vic_tag, req_idx}, wb_cnt);
                    m_data_in = c_data_out;
                end
                ALLOC: begin
                    Stall = 1'b1;
                    m_rd  = issue;
                    if (issue)
                        m_addr = word_addr({req_tag, req_idx}, iss_cnt[1:0]);
                    // Line becomes valid only with its last word, so an
                    // abandoned fill never leaves a half-written valid line.
                    if (fill_valid) begin
                        c_en       = 1'b1;
                        c_write    = 1'b1;
                        c_valid_in = (fill_cnt == 2'd3);
                        c_index    = req_idx;
                        c_offset   = {fill_word, 1'b0};
                        c_tag_in   = req_tag;
                        c_data_in  = m_data_out;
                    end
                end
                RETRY: begin
                    Stall     = 1'b1;
                    c_en      = 1'b1;
                    c_comp    = 1'b1;
                    c_write   = req_wr;
                    c_index   = req_idx;
                    c_offset  = req_addr[OFF_W-1:0];
                    c_tag_in  = req_tag;
                    c_data_in = req_data;
                    Done      = 1'b1;
                    DataOut   = req_wr ? '0 : c_data_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl with behavioural cache array and memory.
// Directed vector table, hand-written stall/reset sequences, random vs. ref model.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    localparam int MEM_LAT = 2;
    localparam int INDEX_W = 5;
    localparam int TAG_W   = 16 - INDEX_W - 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic Rd = 1'b0, Wr = 1'b0;
    logic [15:0] Addr = '0, DataIn = '0;
    logic [15:0] DataOut;
    logic Done, Stall, CacheHit, Err, dcache_req, dcache_hit;
    logic c_en, c_comp, c_write, c_valid_in;
    logic [INDEX_W-1:0] c_index;
    logic [2:0] c_offset;
    logic [TAG_W-1:0] c_tag_in, c_tag_out;
    logic [15:0] c_data_in, c_data_out;
    logic c_hit, c_dirty, c_valid;
    logic [15:0] m_addr, m_data_in, m_data_out;
    logic m_wr, m_rd;
    logic m_stall = 1'b0;

    dcache_ctrl #(.MEM_LAT(MEM_LAT), .INDEX_W(INDEX_W)) dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit),
        .Err(Err), .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .c_en(c_en), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
        .c_index(c_index), .c_offset(c_offset), .c_tag_in(c_tag_in),
        .c_data_in(c_data_in), .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid),
        .c_tag_out(c_tag_out), .c_data_out(c_data_out), .m_addr(m_addr),
        .m_data_in(m_data_in), .m_wr(m_wr), .m_rd(m_rd),
        .m_data_out(m_data_out), .m_stall(m_stall)
    );

    always #5 clk = ~clk;

    logic any_out;
    assign any_out = |{Done, Stall, CacheHit, Err, dcache_req, dcache_hit,
                       c_en, c_comp, c_write, c_valid_in, c_index, c_offset,
                       c_tag_in, c_data_in, DataOut, m_addr, m_data_in, m_wr, m_rd};

    // ---------------- behavioural cache array and memory ----------------
    logic [TAG_W-1:0] ct [32];
    logic             cv [32];
    logic             cd [32];
    logic [15:0]      cdat [32][4];
    logic [15:0]      mem [32768];
    logic [15:0]      pd [MEM_LAT];

    logic do_init = 1'b0, do_pre = 1'b0;
    logic [4:0] pre_idx;
    logic [TAG_W-1:0] pre_tag;
    logic pre_dirty;
    logic [3:0][15:0] pre_d;

    function automatic logic [15:0] init_val(input int w);
        logic [15:0] v;
        v = 16'(w) ^ 16'h5A5A;
        if (w >= 'h20 && w <= 'h23) v = 16'(w - 'h1F);
        if (w == 'h909) v = 16'hBEEF;
        return v;
    endfunction

    always_comb begin
        c_valid    = cv[c_index];
        c_dirty    = cd[c_index];
        c_tag_out  = ct[c_index];
        c_data_out = cdat[c_index][c_offset[2:1]];
        c_hit      = c_en & c_comp & cv[c_index] & (ct[c_index] == c_tag_in);
    end

    assign m_data_out = pd[MEM_LAT-1];

    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 32; i++) begin
                cv[i] <= 1'b0;
                cd[i] <= 1'b0;
                ct[i] <= '0;
            end
            for (int i = 0; i < 32768; i++) mem[i] <= init_val(i);
        end else begin
            if (do_pre) begin
                ct[pre_idx] <= pre_tag;
                cv[pre_idx] <= 1'b1;
                cd[pre_idx] <= pre_dirty;
                for (int k = 0; k < 4; k++) cdat[pre_idx][k] <= pre_d[k];
            end
            if (c_en && c_write) begin
                if (c_comp) begin
                    if (c_hit) begin
                        cdat[c_index][c_offset[2:1]] <= c_data_in;
                        cd[c_index] <= 1'b1;
                    end
                end else begin
                    cdat[c_index][c_offset[2:1]] <= c_data_in;
                    ct[c_index] <= c_tag_in;
                    cv[c_index] <= c_valid_in;
                    cd[c_index] <= 1'b0;
                end
            end
            if (m_wr && !m_stall) mem[m_addr[15:1]] <= m_data_in;
        end
        pd[0] <= mem[m_addr[15:1]];
        for (int i = 1; i < MEM_LAT; i++) pd[i] <= pd[i-1];
    end

    // ---------------- checking helpers ----------------
    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic init_models();
        do_init = 1'b1;
        @(posedge clk); #1;
        do_init = 1'b0;
    endtask

    task automatic preload(input logic [4:0] idx, input logic [TAG_W-1:0] tg,
                           input logic dirty, input logic [3:0][15:0] d);
        pre_idx = idx; pre_tag = tg; pre_dirty = dirty; pre_d = d;
        do_pre = 1'b1;
        @(posedge clk); #1;
        do_pre = 1'b0;
    endtask

    int rd_cyc[$], wr_cyc[$];
    logic [15:0] rd_adr[$], wr_adr[$];
    int nreq, nhitp, nerr, nstall, done_cyc;
    logic [15:0] dout;
    logic hitf;

    // Called at posedge+1; returns at posedge+1 after the Done cycle.
    task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic [31:0] smask, input bit rstall);
        rd_cyc.delete(); wr_cyc.delete(); rd_adr.delete(); wr_adr.delete();
        nreq = 0; nhitp = 0; nerr = 0; nstall = 0; done_cyc = -1;
        dout = '0; hitf = 1'b0;
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        for (int c = 0; c < 300; c++) begin
            if (c < 32) m_stall = smask[c];
            else m_stall = 1'b0;
            if (rstall && $urandom_range(0, 99) < 30) m_stall = 1'b1;
            @(negedge clk);
            if (m_rd && !m_stall) begin rd_cyc.push_back(c); rd_adr.push_back(m_addr); end
            if (m_wr && !m_stall) begin wr_cyc.push_back(c); wr_adr.push_back(m_addr); end
            nreq += int'(dcache_req);
            nhitp += int'(dcache_hit);
            nerr += int'(Err);
            nstall += int'(Stall);
            if (Done) begin
                done_cyc = c; dout = DataOut; hitf = CacheHit;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0; m_stall = 1'b0;
    endtask

    typedef struct {
        string nm;
        logic rd, wr;
        logic [15:0] a, d;
        int exp_done;
        logic exp_hit, exp_err, chk_dout;
        logic [15:0] exp_dout;
        int exp_nrd; logic [15:0] rd_base; int rd_c0;
        int exp_nwr; logic [15:0] wr_base; int wr_c0;
    } vec_t;

    vec_t vt[9];

    // reference model state for the random phase
    logic [7:0] rtag [4];
    logic rv [4], rdty [4];
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] ref_get(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
    endfunction

    initial begin
        vt[0] = '{"hit",   1, 0, 16'h1212, 16'h0,    0, 1, 0, 1, 16'hBEEF, 0, 16'h0, 0, 0, 16'h0, 0};
        vt[1] = '{"clean", 1, 0, 16'h0044, 16'h0,    7, 0, 0, 1, 16'h0003, 4, 16'h0040, 1, 0, 16'h0, 0};
        vt[2] = '{"dirty", 0, 1, 16'h0202, 16'h5555, 11, 0, 0, 0, 16'h0,   4, 16'h0200, 5, 4, 16'h0100, 1};
        vt[3] = '{"rehit", 1, 0, 16'h0202, 16'h0,    0, 1, 0, 1, 16'h5555, 0, 16'h0, 0, 0, 16'h0, 0};
        vt[4] = '{"rdwr",  1, 1, 16'h0000, 16'h0,    0, 0, 1, 0, 16'h0,   0, 16'h0, 0, 0, 16'h0, 0};
        vt[5] = '{"odd",   1, 0, 16'h0003, 16'h0,    0, 0, 1, 0, 16'h0,   0, 16'h0, 0, 0, 16'h0, 0};
        vt[6] = '{"fillhit",1,0, 16'h0046, 16'h0,    0, 1, 0, 1, 16'h0004, 0, 16'h0, 0, 0, 16'h0, 0};
        vt[7] = '{"sthit", 0, 1, 16'h1214, 16'h7777, 0, 1, 0, 0, 16'h0,   0, 16'h0, 0, 0, 16'h0, 0};
        vt[8] = '{"ldst",  1, 0, 16'h1214, 16'h0,    0, 1, 0, 1, 16'h7777, 0, 16'h0, 0, 0, 16'h0, 0};

        // reset holds every output low even with a request present
        Rd = 1'b1; Addr = 16'h0044;
        #2;
        chk("rst_outs_req", 32'(any_out), 0);
        Rd = 1'b0;
        init_models();
        preload(5'd2, 8'h12, 1'b0, {init_val('h90B), init_val('h90A), 16'hBEEF, init_val('h908)});
        preload(5'd0, 8'h01, 1'b1, {16'hA003, 16'hA002, 16'hA001, 16'hA000});
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_outs", 32'(any_out), 0);
        @(posedge clk); #1;

        // ---------------- directed table ----------------
        for (int i = 0; i < 9; i++) begin
            access(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, 32'h0, 1'b0);
            chk({vt[i].nm, "_done"}, 32'(done_cyc), 32'(vt[i].exp_done));
            chk({vt[i].nm, "_hit"}, 32'(hitf), 32'(vt[i].exp_hit));
            chk({vt[i].nm, "_hitp"}, 32'(nhitp), 32'(vt[i].exp_hit));
            chk({vt[i].nm, "_err"}, 32'(nerr), 32'(vt[i].exp_err));
            chk({vt[i].nm, "_req"}, 32'(nreq), vt[i].exp_err ? 0 : 1);
            chk({vt[i].nm, "_stall"}, 32'(nstall), 32'(vt[i].exp_done));
            if (vt[i].chk_dout)
                chk({vt[i].nm, "_dout"}, 32'(dout), 32'(vt[i].exp_dout));
            chk({vt[i].nm, "_nrd"}, 32'(rd_adr.size()), 32'(vt[i].exp_nrd));
            chk({vt[i].nm, "_nwr"}, 32'(wr_adr.size()), 32'(vt[i].exp_nwr));
            for (int k = 0; k < rd_adr.size() && k < vt[i].exp_nrd; k++) begin
                chk({vt[i].nm, "_rdaddr"}, 32'(rd_adr[k]), 32'(vt[i].rd_base + 16'(2 * k)));
                chk({vt[i].nm, "_rdcyc"}, 32'(rd_cyc[k]), 32'(vt[i].rd_c0 + k));
            end
            for (int k = 0; k < wr_adr.size() && k < vt[i].exp_nwr; k++) begin
                chk({vt[i].nm, "_wraddr"}, 32'(wr_adr[k]), 32'(vt[i].wr_base + 16'(2 * k)));
                chk({vt[i].nm, "_wrcyc"}, 32'(wr_cyc[k]), 32'(vt[i].wr_c0 + k));
            end
        end
        for (int k = 0; k < 4; k++)
            chk("wb_mem", 32'(mem['h80 + k]), 32'(16'hA000 + 16'(k)));

        // ---------------- miss with memory back-pressure ----------------
        access(1'b1, 1'b0, 16'h0082, 16'h0, 32'b1100, 1'b0);
        chk("stl_done", 32'(done_cyc), 9);
        chk("stl_dout", 32'(dout), 32'(init_val('h41)));
        chk("stl_nrd", 32'(rd_adr.size()), 4);
        if (rd_cyc.size() == 4) begin
            chk("stl_c0", 32'(rd_cyc[0]), 1);
            chk("stl_c1", 32'(rd_cyc[1]), 4);
            chk("stl_c2", 32'(rd_cyc[2]), 5);
            chk("stl_c3", 32'(rd_cyc[3]), 6);
            chk("stl_a1", 32'(rd_adr[1]), 32'h82);
        end

        // ---------------- reset in the middle of a fill ----------------
        Rd = 1'b1; Addr = 16'h00C6;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_outs", 32'(any_out), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_hold", 32'(any_out), 0);
        Rd = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 16'h00C6, 16'h0, 32'h0, 1'b0);
        chk("postrst_done", 32'(done_cyc), 7);
        chk("postrst_hit", 32'(hitf), 0);
        chk("postrst_dout", 32'(dout), 32'(init_val('h63)));
        chk("postrst_nrd", 32'(rd_adr.size()), 4);

        // ---------------- random traffic vs. reference model ----------------
        init_models();
        for (int i = 0; i < 4; i++) begin rv[i] = 1'b0; rdty[i] = 1'b0; rtag[i] = '0; end
        ref_mem.delete();
        for (int n = 0; n < 200; n++) begin
            bit rs;
            int kind, ix;
            logic [7:0] tg;
            logic [1:0] w;
            logic [15:0] a, d;
            logic rd, wr, hit_e, dirty_e;
            rs = (n >= 120);
            kind = $urandom_range(0, 9);
            tg = 8'(32'h30 + $urandom_range(0, 3));
            ix = $urandom_range(0, 3);
            w = 2'($urandom_range(0, 3));
            a = {tg, 5'(ix), w, 1'b0};
            d = 16'($urandom);
            rd = 1'($urandom_range(0, 1));
            wr = ~rd;
            if (kind == 0) begin rd = 1'b1; wr = 1'b1; end
            if (kind == 1) a[0] = 1'b1;
            access(rd, wr, a, d, 32'h0, rs);
            if (kind <= 1) begin
                chk("rnd_err", 32'(nerr), 1);
                chk("rnd_err_done", 32'(done_cyc), 0);
                chk("rnd_err_req", 32'(nreq), 0);
                chk("rnd_err_mem", 32'(rd_adr.size() + wr_adr.size()), 0);
            end else begin
                hit_e = rv[ix] && rtag[ix] == tg;
                dirty_e = !hit_e && rv[ix] && rdty[ix];
                chk("rnd_hit", 32'(hitf), 32'(hit_e));
                chk("rnd_req", 32'(nreq), 1);
                chk("rnd_nrd", 32'(rd_adr.size()), hit_e ? 0 : 4);
                chk("rnd_nwr", 32'(wr_adr.size()), dirty_e ? 4 : 0);
                if (!rs)
                    chk("rnd_lat", 32'(done_cyc), hit_e ? 0 : (dirty_e ? 11 : 7));
                else
                    chk("rnd_fin", 32'(done_cyc >= 0), 1);
                if (rd)
                    chk("rnd_dout", 32'(dout), 32'(ref_get(int'(a[15:1]))));
                else
                    ref_mem[int'(a[15:1])] = d;
                if (!hit_e) begin rtag[ix] = tg; rv[ix] = 1'b1; rdty[ix] = 1'b0; end
                if (wr) rdty[ix] = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
